// File: rtl/freqgen_pkg.sv
// Shared types and helpers for the rational-ratio frequency generator.
// FREQGEN_SYNC_UPDATE_EN (see freqgen_core) selects whether ST_ARMED is used.
package freqgen_pkg;

    localparam int unsigned FREQGEN_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ARMED = 2'd2
    } freqgen_state_e;

    // A usable ratio produces at most one output edge per clock: 0 < M <= D.
    function automatic logic ratio_valid(input int unsigned m, input int unsigned d);
        return (m != 0) && (d != 0) && (m <= d);
    endfunction

endpackage

// File: rtl/freqgen_if.sv
// Command/status bundle between the command decoder and the frequency generator.
interface freqgen_if
    import freqgen_pkg::*;
#(
    parameter int unsigned WIDTH = FREQGEN_DEF_WIDTH
);
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] divider;
    logic             change;
    logic             enable;
    logic             freq_out;
    logic             tick;
    logic             active;
    logic             cfg_err;
    logic             update_ack;

    modport master (
        output multiplier, divider, change, enable,
        input  freq_out, tick, active, cfg_err, update_ack
    );

    modport slave (
        input  multiplier, divider, change, enable,
        output freq_out, tick, active, cfg_err, update_ack
    );
endinterface

// File: rtl/freqgen_accum.sv
// Bresenham phase accumulator: adds M each running cycle, wraps at D and flags the wrap.
module freqgen_accum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_m,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_ovf_c,
    output logic             o_tick
);
    logic [ACC_W-1:0] r_acc;
    logic             r_tick;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_next;
    logic             w_ovf;

    // acc < D and M <= D keep the sum below 2*D, so one subtraction suffices.
    assign w_sum   = r_acc + ACC_W'(i_m);
    assign w_ovf   = i_run && (w_sum >= ACC_W'(i_d));
    assign w_next  = w_ovf ? (w_sum - ACC_W'(i_d)) : w_sum;
    assign o_ovf_c = w_ovf;
    assign o_tick  = r_tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_ovf;
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_run) begin
                r_acc <= w_next;
            end
        end
    end

endmodule

// File: rtl/freqgen_core.sv
// Rational-ratio square-wave generator: freq_out = f_clk*M/(2*D), tick = f_clk*M/D.
// Define FREQGEN_SYNC_UPDATE_EN to defer ratio changes to the next freq_out rising edge.
module freqgen_core
    import freqgen_pkg::*;
#(
    parameter int unsigned WIDTH = FREQGEN_DEF_WIDTH,
    parameter int unsigned ACC_W = WIDTH + 1
) (
    input  logic      clk,
    input  logic      reset_n,
    freqgen_if.slave  bus
);
    freqgen_state_e   r_state;
    logic [WIDTH-1:0] r_cur_m;
    logic [WIDTH-1:0] r_cur_d;
    logic             r_freq_out;
    logic             r_active;
    logic             r_cfg_err;
    logic             r_update_ack;

    logic             w_cmd_valid;
    logic             w_cur_valid;
    logic             w_running;
    logic             w_acc_run;
    logic             w_acc_clr;
    logic             w_ovf;
    logic             w_tick;

    assign w_cmd_valid = bus.change && ratio_valid(32'(bus.multiplier), 32'(bus.divider));
    assign w_cur_valid = ratio_valid(32'(r_cur_m), 32'(r_cur_d));
    assign w_running   = bus.enable && (r_state != ST_STOP);

`ifdef FREQGEN_SYNC_UPDATE_EN
    logic [WIDTH-1:0] r_pend_m;
    logic [WIDTH-1:0] r_pend_d;
    logic             r_pend_flag;
    logic             w_apply;

    // Swap ratios only on a wrap that raises freq_out, so the high phase starts clean.
    assign w_apply   = w_running && (r_state == ST_ARMED) && r_pend_flag && w_ovf && !r_freq_out;
    assign w_acc_run = w_running;
    assign w_acc_clr = !w_running || w_apply;
`else
    logic w_reload;

    assign w_reload  = w_running && w_cmd_valid;
    assign w_acc_run = w_running && !w_reload;
    assign w_acc_clr = !w_running || w_reload;
`endif

    freqgen_accum #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .i_run   (w_acc_run),
        .i_clr   (w_acc_clr),
        .i_m     (r_cur_m),
        .i_d     (r_cur_d),
        .o_ovf_c (w_ovf),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_STOP;
            r_cur_m      <= '0;
            r_cur_d      <= '0;
            r_freq_out   <= 1'b0;
            r_active     <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_update_ack <= 1'b0;
`ifdef FREQGEN_SYNC_UPDATE_EN
            r_pend_m     <= '0;
            r_pend_d     <= '0;
            r_pend_flag  <= 1'b0;
`endif
        end else begin
            r_update_ack <= 1'b0;
            if (bus.change) begin
                r_cfg_err <= !w_cmd_valid;
            end

            if (!bus.enable || r_state == ST_STOP) begin
                // Stopped (or being stopped): ratio loads directly, output held low.
                r_freq_out <= 1'b0;
`ifdef FREQGEN_SYNC_UPDATE_EN
                r_pend_flag <= 1'b0;
`endif
                if (w_cmd_valid) begin
                    r_cur_m      <= bus.multiplier;
                    r_cur_d      <= bus.divider;
                    r_update_ack <= 1'b1;
                end
                if (bus.enable && w_cur_valid) begin
                    r_state  <= ST_RUN;
                    r_active <= 1'b1;
                end else begin
                    r_state  <= ST_STOP;
                    r_active <= 1'b0;
                end
            end else begin
                r_freq_out <= r_freq_out ^ w_ovf;
`ifdef FREQGEN_SYNC_UPDATE_EN
                if (w_apply) begin
                    r_cur_m      <= r_pend_m;
                    r_cur_d      <= r_pend_d;
                    r_pend_flag  <= 1'b0;
                    r_update_ack <= 1'b1;
                    r_state      <= ST_RUN;
                end
                // A change coinciding with an apply re-arms with the newer ratio.
                if (w_cmd_valid) begin
                    r_pend_m    <= bus.multiplier;
                    r_pend_d    <= bus.divider;
                    r_pend_flag <= 1'b1;
                    r_state     <= ST_ARMED;
                end
`else
                if (w_cmd_valid) begin
                    r_cur_m      <= bus.multiplier;
                    r_cur_d      <= bus.divider;
                    r_freq_out   <= 1'b0;
                    r_update_ack <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.freq_out   = r_freq_out;
    assign bus.tick       = w_tick;
    assign bus.active     = r_active;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.update_ack = r_update_ack;

endmodule
